read_data: RTL and testbench

AXI read-data (R) channel router of the 2-master/3-slave interconnect. It is the return path for the read-address channel and carries R beats from slaves S0/S1/S2 back to masters M0/M1. A round-robin arbiter chooses among slaves with RVALID asserted. The burst is locked to the granted slave until RLAST, and the upper ID bits steer the beats to the owning master.

---
 rtl/read_data.sv | 99 +++++++++
 tb/tb_read_data.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/read_data.sv
// read_data: AXI R-channel router, 3 slaves to 2 masters, round-robin with burst lock.
module read_data #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDS_BITS-1:0]  RID_S0,
  input  logic [DATA_BITS-1:0] RDATA_S0,
  input  logic [1:0]           RRESP_S0,
  input  logic                 RLAST_S0,
  input  logic                 RVALID_S0,
  output logic                 RREADY_S0,
  input  logic [IDS_BITS-1:0]  RID_S1,
  input  logic [DATA_BITS-1:0] RDATA_S1,
  input  logic [1:0]           RRESP_S1,
  input  logic                 RLAST_S1,
  input  logic                 RVALID_S1,
  output logic                 RREADY_S1,
  input  logic [IDS_BITS-1:0]  RID_S2,
  input  logic [DATA_BITS-1:0] RDATA_S2,
  input  logic [1:0]           RRESP_S2,
  input  logic                 RLAST_S2,
  input  logic                 RVALID_S2,
  output logic                 RREADY_S2,
  output logic [ID_BITS-1:0]   RID_M0,
  output logic [DATA_BITS-1:0] RDATA_M0,
  output logic [1:0]           RRESP_M0,
  output logic                 RLAST_M0,
  output logic                 RVALID_M0,
  input  logic                 RREADY_M0,
  output logic [ID_BITS-1:0]   RID_M1,
  output logic [DATA_BITS-1:0] RDATA_M1,
  output logic [1:0]           RRESP_M1,
  output logic                 RLAST_M1,
  output logic                 RVALID_M1,
  input  logic                 RREADY_M1
);
  localparam int TB = IDS_BITS - ID_BITS;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [1:0] gnt_q, gnt_d, rr_q, rr_d;
  logic [3:0] vld, lst;
  logic [IDS_BITS-1:0] rid [4];
  logic [DATA_BITS-1:0] rdat [4];
  logic [1:0] rrsp [4];
  logic [1:0] r1, r2, win, sel, nxt;
  logic any, act, to_m0, to_m1, rdy_m, hs, last;
  logic [TB-1:0] tag;
  // Entry 3 is a dead slot so 2-bit selects stay in range.
  assign vld  = {1'b0, RVALID_S2, RVALID_S1, RVALID_S0};
  assign lst  = {1'b0, RLAST_S2, RLAST_S1, RLAST_S0};
  assign rid  = '{RID_S0, RID_S1, RID_S2, '0};
  assign rdat = '{RDATA_S0, RDATA_S1, RDATA_S2, '0};
  assign rrsp = '{RRESP_S0, RRESP_S1, RRESP_S2, 2'b00};
  always_comb begin
    r1      = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    r2      = (r1 == 2'd2) ? 2'd0 : r1 + 2'd1;
    win     = vld[rr_q] ? rr_q : vld[r1] ? r1 : r2;
    any     = |vld;
    sel     = (state_q == BURST) ? gnt_q : win;
    act     = !rst && (state_q == BURST || any);
    tag     = rid[sel][IDS_BITS-1:ID_BITS];
    to_m0   = act && tag == TB'(1);
    to_m1   = act && tag == TB'(2);
    rdy_m   = to_m0 ? RREADY_M0 : to_m1 ? RREADY_M1 : 1'b1;
    hs      = act && vld[sel] && rdy_m;
    last    = lst[sel];
    nxt     = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    state_d = (hs && last) ? IDLE : act ? BURST : state_q;
    gnt_d   = (state_q == IDLE && act) ? sel : gnt_q;
    rr_d    = (hs && last) ? nxt : rr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      rr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end
  assign RREADY_S0 = act && rdy_m && sel == 2'd0;
  assign RREADY_S1 = act && rdy_m && sel == 2'd1;
  assign RREADY_S2 = act && rdy_m && sel == 2'd2;
  assign RVALID_M0 = to_m0 && vld[sel];
  assign RID_M0    = to_m0 ? rid[sel][ID_BITS-1:0] : '0;
  assign RDATA_M0  = to_m0 ? rdat[sel] : '0;
  assign RRESP_M0  = to_m0 ? rrsp[sel] : 2'b00;
  assign RLAST_M0  = to_m0 && last;
  assign RVALID_M1 = to_m1 && vld[sel];
  assign RID_M1    = to_m1 ? rid[sel][ID_BITS-1:0] : '0;
  assign RDATA_M1  = to_m1 ? rdat[sel] : '0;
  assign RRESP_M1  = to_m1 ? rrsp[sel] : 2'b00;
  assign RLAST_M1  = to_m1 && last;
endmodule

// File: tb/tb_read_data.sv
// tb_read_data: directed vector table, hand sequences and random run against a reference model.
module tb_read_data;
  logic clk = 0, rst;
  logic [7:0] RID_S0, RID_S1, RID_S2;
  logic [31:0] RDATA_S0, RDATA_S1, RDATA_S2;
  logic [1:0] RRESP_S0, RRESP_S1, RRESP_S2;
  logic RLAST_S0, RLAST_S1, RLAST_S2, RVALID_S0, RVALID_S1, RVALID_S2;
  logic RREADY_S0, RREADY_S1, RREADY_S2;
  logic [3:0] RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0] RRESP_M0, RRESP_M1;
  logic RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  int n_cmp = 0, n_bad = 0;
  int locked = -1, rr = 0;
  typedef struct {
    bit r; bit [2:0] v, l; bit [7:0] i0, i1, i2; bit [1:0] mr, evm; bit [2:0] ers;
  } vec_t;
  vec_t vecs[$];

  read_data dut (
    .clk(clk), .rst(rst),
    .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0), .RLAST_S0(RLAST_S0),
    .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
    .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1), .RLAST_S1(RLAST_S1),
    .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
    .RID_S2(RID_S2), .RDATA_S2(RDATA_S2), .RRESP_S2(RRESP_S2), .RLAST_S2(RLAST_S2),
    .RVALID_S2(RVALID_S2), .RREADY_S2(RREADY_S2),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic set_in(bit r, bit [2:0] v, bit [2:0] l, bit [7:0] i0, bit [7:0] i1, bit [7:0] i2, bit [1:0] mr);
    rst = r;
    {RVALID_S2, RVALID_S1, RVALID_S0} = v;
    {RLAST_S2, RLAST_S1, RLAST_S0} = l;
    RID_S0 = i0; RID_S1 = i1; RID_S2 = i2;
    RDATA_S0 = $urandom; RDATA_S1 = $urandom; RDATA_S2 = $urandom;
    RRESP_S0 = 2'($urandom_range(0, 3)); RRESP_S1 = 2'($urandom_range(0, 3));
    RRESP_S2 = 2'($urandom_range(0, 3));
    {RREADY_M1, RREADY_M0} = mr;
  endtask

  // One cycle: compare against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [7:0] id[3];
    logic [31:0] d[3];
    logic [1:0] rs[3];
    bit [2:0] v, l;
    bit [1:0] evm;
    bit [2:0] ers;
    int s, tgt, tag;
    bit mready, hs;
    #4;
    id = '{RID_S0, RID_S1, RID_S2};
    d  = '{RDATA_S0, RDATA_S1, RDATA_S2};
    rs = '{RRESP_S0, RRESP_S1, RRESP_S2};
    v = {RVALID_S2, RVALID_S1, RVALID_S0};
    l = {RLAST_S2, RLAST_S1, RLAST_S0};
    s = -1; tgt = -1; evm = 0; ers = 0; hs = 0;
    if (!rst) begin
      if (locked >= 0) s = locked;
      else for (int k = 0; k < 3; k++) if (s < 0 && v[(rr + k) % 3]) s = (rr + k) % 3;
    end
    if (s >= 0) begin
      tag = int'(id[s]) / 16;
      tgt = (tag == 1) ? 0 : (tag == 2) ? 1 : -1;
      mready = (tgt < 0) ? 1'b1 : (tgt == 0 ? RREADY_M0 : RREADY_M1);
      ers[s] = mready;
      if (tgt >= 0) evm[tgt] = v[s];
      hs = v[s] && mready;
    end
    chk("rvalid_m", {RVALID_M1, RVALID_M0}, evm);
    chk("rready_s", {RREADY_S2, RREADY_S1, RREADY_S0}, ers);
    if (tgt == 0 && v[s])
      chk("m0_beat", {RID_M0, RDATA_M0, RRESP_M0, RLAST_M0}, {id[s][3:0], d[s], rs[s], l[s]});
    if (tgt == 1 && v[s])
      chk("m1_beat", {RID_M1, RDATA_M1, RRESP_M1, RLAST_M1}, {id[s][3:0], d[s], rs[s], l[s]});
    if (rst)
      chk("rst_zero", {RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RID_M1, RDATA_M1, RRESP_M1, RLAST_M1}, 0);
    @(posedge clk);
    if (rst) begin locked = -1; rr = 0; end
    else if (s >= 0) begin
      if (hs && l[s]) begin locked = -1; rr = (s + 1) % 3; end
      else locked = s;
    end
    #1;
  endtask

  task automatic add(bit r, bit [2:0] v, bit [2:0] l, bit [7:0] i0, bit [7:0] i1, bit [7:0] i2,
                     bit [1:0] mr, bit [1:0] evm, bit [2:0] ers);
    vec_t x;
    x.r = r; x.v = v; x.l = l; x.i0 = i0; x.i1 = i1; x.i2 = i2; x.mr = mr; x.evm = evm; x.ers = ers;
    vecs.push_back(x);
  endtask

  initial begin
    bit [3:0] tags[5] = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h4};
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    add(1, 7, 7, 8'h15, 8'h23, 8'h17, 3, 0, 0);
    add(0, 2, 2, 8'h00, 8'h13, 8'h00, 1, 1, 2);
    for (int k = 0; k < 5; k++)
      add(0, 7, 7, 8'h15, 8'h23, 8'h17, 3, (k == 2) ? 2'd2 : 2'd1, (k % 3 == 0) ? 3'd4 : (k % 3 == 1) ? 3'd1 : 3'd2);
    add(0, 4, 4, 8'h00, 8'h00, 8'h17, 3, 1, 4);
    for (int k = 0; k < 3; k++) add(0, 5, 0, 8'h25, 8'h00, 8'h17, 3, 2, 1);
    add(0, 5, 5, 8'h25, 8'h00, 8'h17, 3, 2, 1);
    add(0, 4, 4, 8'h00, 8'h00, 8'h17, 3, 1, 4);
    add(0, 4, 4, 8'h25, 8'h00, 8'h17, 0, 1, 0);
    add(0, 5, 5, 8'h25, 8'h00, 8'h17, 0, 1, 0);
    add(0, 5, 5, 8'h25, 8'h00, 8'h17, 0, 1, 0);
    add(0, 5, 5, 8'h25, 8'h00, 8'h17, 1, 1, 4);
    add(0, 1, 1, 8'h25, 8'h00, 8'h00, 3, 2, 1);
    add(0, 2, 0, 8'h00, 8'h45, 8'h00, 0, 0, 2);
    add(0, 2, 2, 8'h00, 8'h45, 8'h00, 0, 0, 2);
    add(0, 4, 0, 8'h00, 8'h00, 8'h17, 3, 1, 4);
    add(1, 4, 0, 8'h00, 8'h00, 8'h17, 3, 0, 0);
    add(0, 6, 6, 8'h00, 8'h23, 8'h17, 3, 2, 2);
    foreach (vecs[i]) begin
      set_in(vecs[i].r, vecs[i].v, vecs[i].l, vecs[i].i0, vecs[i].i1, vecs[i].i2, vecs[i].mr);
      #3;
      chk($sformatf("vec%0d_rvalid_m", i), {RVALID_M1, RVALID_M0}, vecs[i].evm);
      chk($sformatf("vec%0d_rready_s", i), {RREADY_S2, RREADY_S1, RREADY_S0}, vecs[i].ers);
      #(-0); step_after_table();
    end
    // Slave bubble mid-burst: S0 to M0 pauses while S1 is waiting.
    set_in(0, 1, 0, 8'h11, 8'h23, 8'h00, 3); step();
    set_in(0, 2, 2, 8'h11, 8'h23, 8'h00, 3); #2;
    chk("bubble_rvalid_m0", RVALID_M0, 0);
    chk("bubble_rready_s1", RREADY_S1, 0);
    chk("bubble_rready_s0", RREADY_S0, 1);
    step_after_table();
    set_in(0, 3, 3, 8'h11, 8'h23, 8'h00, 3); step();
    set_in(0, 2, 2, 8'h11, 8'h23, 8'h00, 3); #2;
    chk("after_bubble_s1", {RREADY_S1, RVALID_M1}, 2'b11);
    step_after_table();
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 39) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             {tags[$urandom_range(0, 4)], 4'($urandom)}, {tags[$urandom_range(0, 4)], 4'($urandom)},
             {tags[$urandom_range(0, 4)], 4'($urandom)}, 2'($urandom_range(0, 3)));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Finishes a cycle whose inputs were set a few time units earlier.
  task automatic step_after_table();
    logic [7:0] id[3];
    bit [2:0] v, l;
    bit [1:0] evm;
    bit [2:0] ers;
    int s, tgt;
    bit mready;
    id = '{RID_S0, RID_S1, RID_S2};
    v = {RVALID_S2, RVALID_S1, RVALID_S0};
    l = {RLAST_S2, RLAST_S1, RLAST_S0};
    s = -1; tgt = -1; evm = 0; ers = 0; mready = 0;
    if (!rst) begin
      if (locked >= 0) s = locked;
      else for (int k = 0; k < 3; k++) if (s < 0 && v[(rr + k) % 3]) s = (rr + k) % 3;
    end
    if (s >= 0) begin
      tgt = (int'(id[s]) / 16 == 1) ? 0 : (int'(id[s]) / 16 == 2) ? 1 : -1;
      mready = (tgt < 0) ? 1'b1 : (tgt == 0 ? RREADY_M0 : RREADY_M1);
      ers[s] = mready;
      if (tgt >= 0) evm[tgt] = v[s];
    end
    chk("model_rvalid_m", {RVALID_M1, RVALID_M0}, evm);
    chk("model_rready_s", {RREADY_S2, RREADY_S1, RREADY_S0}, ers);
    @(posedge clk);
    if (rst) begin locked = -1; rr = 0; end
    else if (s >= 0) begin
      if (v[s] && mready && l[s]) begin locked = -1; rr = (s + 1) % 3; end
      else locked = s;
    end
    #1;
  endtask
endmodule
